// File: rtl/game_ctrl_pkg.sv
// Shared game-control definitions: FSM state encoding and BCD digit width.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int unsigned BCD_W = 4;

endpackage

// File: rtl/game_ctrl_if.sv
// Game-control signal bundle: frame/button/collision inputs, status and score outputs.
interface game_ctrl_if
  import game_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) ();

  logic                      tick;
  logic                      btn;
  logic                      collide;
  logic                      running;
  logic                      game_over;
  logic                      clear;
  logic [BCD_W*DIGITS-1:0]   score;
  logic [BCD_W*DIGITS-1:0]   hiscore;

  modport master (
    output tick, btn, collide,
    input  running, game_over, clear, score, hiscore
  );

  modport slave (
    input  tick, btn, collide,
    output running, game_over, clear, score, hiscore
  );

endinterface

// File: rtl/game_ctrl_bcd_counter.sv
// Multi-digit packed-BCD up-counter with synchronous clear and all-nines saturation.
module bcd_counter
  import game_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [BCD_W*DIGITS-1:0] count_o
);

  localparam logic [BCD_W*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  logic [BCD_W*DIGITS-1:0] count_q, count_d;
  logic                    carry;

  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != NINES)) begin
      // Ripple the +1 through digits; a 9 rolls to 0 and passes the carry on.
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (count_q[i*BCD_W +: BCD_W] == 4'd9) begin
            count_d[i*BCD_W +: BCD_W] = '0;
          end else begin
            count_d[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: start button, scoring while running, hit freeze, game-over and hiscore.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_DIV = 6,
  parameter int unsigned HIT_TICKS = 30,
  parameter int unsigned DIGITS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  game_ctrl_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(SCORE_DIV + 1);
  localparam int unsigned HIT_W = $clog2(HIT_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_DIV - 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_TICKS - 1);

  state_e state_q, state_d;

  logic                    sync1_q, sync2_q, sync3_q;
  logic [1:0]              vld_q;
  logic                    block_q;
  logic                    press_q;

  logic [DIV_W-1:0]        div_q, div_d;
  logic [HIT_W-1:0]        hit_q, hit_d;
  logic [BCD_W*DIGITS-1:0] hiscore_q, hiscore_d;
  logic                    running_q, running_d;
  logic                    game_over_q, game_over_d;
  logic                    clear_q, clear_d;
  logic                    score_clr, score_inc;
  logic [BCD_W*DIGITS-1:0] score;

  // Button path: 2-flop synchroniser, edge detect, and a block that suppresses a
  // press for a button already held at reset until it has been seen released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      vld_q   <= '0;
      block_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1] && !sync2_q) begin
        block_q <= 1'b0;
      end
      press_q <= sync2_q && !sync3_q && !block_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hit_d     = hit_q;
    hiscore_d = hiscore_q;
    clear_d   = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (press_q) begin
          state_d   = ST_RUN;
          clear_d   = 1'b1;
          score_clr = 1'b1;
          div_d     = '0;
        end
      end
      ST_RUN: begin
        if (bus.tick) begin
          if (bus.collide) begin
            state_d = ST_HIT;
            hit_d   = '0;
          end else if (div_q == DIV_LAST) begin
            div_d     = '0;
            score_inc = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      ST_HIT: begin
        if (bus.tick) begin
          if (hit_q == HIT_LAST) begin
            state_d = ST_OVER;
            // Packed BCD orders the same as the numeric value.
            if (score > hiscore_q) begin
              hiscore_d = score;
            end
          end else begin
            hit_d = hit_q + HIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      hit_q       <= '0;
      hiscore_q   <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hit_q       <= hit_d;
      hiscore_q   <= hiscore_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
      clear_q     <= clear_d;
    end
  end

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_score (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .count_o (score)
  );

  assign bus.running   = running_q;
  assign bus.game_over = game_over_q;
  assign bus.clear     = clear_q;
  assign bus.score     = score;
  assign bus.hiscore   = hiscore_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected output snapshots, monitor compares.
module tb_game_ctrl;

  logic clk;
  logic reset;

  game_ctrl_if #(.DIGITS(4)) bus ();

  game_ctrl #(
    .SCORE_DIV (6),
    .HIT_TICKS (30),
    .DIGITS    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        running;
    logic        game_over;
    logic        clear;
    logic [15:0] score;
    logic [15:0] hiscore;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: consumes every queued expectation at the falling edge after it was posted.
  always @(negedge clk) begin
    snap_t e;
    snap_t a;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {bus.running, bus.game_over, bus.clear, bus.score, bus.hiscore};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got run=%0b over=%0b clr=%0b score=%h hi=%h, want run=%0b over=%0b clr=%0b score=%h hi=%h",
                 n, a.running, a.game_over, a.clear, a.score, a.hiscore,
                 e.running, e.game_over, e.clear, e.score, e.hiscore);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic r, input logic go, input logic cl,
                            input logic [15:0] sc, input logic [15:0] hs);
    snap_t e;
    e = {r, go, cl, sc, hs};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_tick(input logic col);
    bus.tick    = 1'b1;
    bus.collide = col;
    step(1);
    bus.tick    = 1'b0;
    bus.collide = 1'b0;
    step(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  // Press: synchroniser + edge register take 3 edges, FSM moves on the 4th.
  task automatic start_game(input string nm, input logic [15:0] hs);
    bus.btn = 1'b1;
    step(4);
    expect_out({nm, "_clr_on"}, 1'b1, 1'b0, 1'b1, 16'h0000, hs);
    bus.btn = 1'b0;
    step(1);
    expect_out({nm, "_clr_off"}, 1'b1, 1'b0, 1'b0, 16'h0000, hs);
    step(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.tick    = 1'b0;
    bus.btn     = 1'b0;
    bus.collide = 1'b0;
    step(3);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    step(5);
    expect_out("idle", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Game 1: score to 0012, stray collide between ticks, hit, freeze, over.
    start_game("g1", 16'h0000);
    ticks(18);
    expect_out("g1_18ticks", 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
    ticks(54);
    expect_out("g1_72ticks", 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000);
    bus.collide = 1'b1;
    step(3);
    bus.collide = 1'b0;
    step(1);
    expect_out("g1_collide_no_tick", 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000);
    bus.tick = 1'b1; bus.collide = 1'b1;
    step(1);
    bus.tick = 1'b0; bus.collide = 1'b0;
    expect_out("g1_hit", 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000);
    bus.btn = 1'b1;
    step(6);
    bus.btn = 1'b0;
    step(4);
    expect_out("g1_btn_in_hit", 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000);
    ticks(29);
    expect_out("g1_hit_29", 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000);
    ticks(1);
    expect_out("g1_over", 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0012);

    // Game 2: ends at 0007 via tick+collide+press in one cycle; hiscore kept.
    start_game("g2", 16'h0012);
    ticks(42);
    expect_out("g2_0007", 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0012);
    bus.btn = 1'b1;
    step(3);
    bus.tick = 1'b1; bus.collide = 1'b1;
    step(1);
    bus.tick = 1'b0; bus.collide = 1'b0;
    expect_out("g2_combo_hit", 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0012);
    bus.btn = 1'b0;
    step(1);
    expect_out("g2_combo_noclr", 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0012);
    ticks(30);
    expect_out("g2_over", 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0012);

    // Game 3: ends at 0020, new hiscore.
    start_game("g3", 16'h0012);
    ticks(120);
    do_tick(1'b1);
    ticks(30);
    expect_out("g3_over", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0020);

    // Game 4: tick held every cycle up to and past saturation.
    start_game("g4", 16'h0020);
    bus.tick = 1'b1;
    step(59988);
    expect_out("g4_9998", 1'b1, 1'b0, 1'b0, 16'h9998, 16'h0020);
    step(6);
    expect_out("g4_9999", 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0020);
    step(6);
    bus.tick = 1'b0;
    expect_out("g4_saturate", 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0020);
    step(1);
    do_tick(1'b1);
    ticks(30);
    expect_out("g4_over", 1'b0, 1'b1, 1'b0, 16'h9999, 16'h9999);

    // Game 5: reset during HIT at 0050 with button held across reset.
    start_game("g5", 16'h9999);
    ticks(300);
    expect_out("g5_0050", 1'b1, 1'b0, 1'b0, 16'h0050, 16'h9999);
    do_tick(1'b1);
    ticks(3);
    bus.btn = 1'b1;
    step(2);
    reset = 1'b0;
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    expect_out("g5_reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    step(12);
    expect_out("g5_held_btn", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    bus.btn = 1'b0;
    step(4);
    start_game("g6", 16'h0000);

    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
